// File: rtl/cclut_lut_writer_pkg.sv
// Shared sizing, state encoding and pattern-word field helpers for the CCLUT
// pattern tables and their writer/lookup logic.
package cclut_lut_writer_pkg;

  localparam int MXADRB = 11;  // table address bits
  localparam int MXDATB = 9;   // table data bits
  localparam int NTBL   = 5;   // number of pattern tables
  localparam int RD_LAT = 1;   // clocks from lut_re to valid lut_rdata
  localparam int RDCNTB = 4;   // read-latency counter width

  localparam int BEND_LSB = 0;
  localparam int BEND_W   = 5;
  localparam int OFFS_LSB = 5;
  localparam int OFFS_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RDWAIT,
    ST_CLEAR,
    ST_FIN
  } state_t;

  function automatic logic [BEND_W-1:0] lut_bend(input logic [MXDATB-1:0] d);
    return d[BEND_LSB +: BEND_W];
  endfunction

  function automatic logic [OFFS_W-1:0] lut_offs(input logic [MXDATB-1:0] d);
    return d[OFFS_LSB +: OFFS_W];
  endfunction

  function automatic logic pid_valid(input logic [2:0] pid);
    return pid < 3'(NTBL);
  endfunction

endpackage

// File: rtl/cclut_lut_writer_ptr_ctr.sv
// Table address pointer: load, auto-increment and sticky wrap flag.
module cclut_ptr_ctr
  import cclut_lut_writer_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              load,
  input  logic [MXADRB-1:0] load_val,
  input  logic              inc,
  output logic [MXADRB-1:0] ptr,
  output logic              wrap
);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ptr  <= '0;
      wrap <= 1'b0;
    end else if (clr) begin
      ptr  <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      ptr <= load_val;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
      if (ptr == '1) wrap <= 1'b1;
    end
  end

endmodule

// File: rtl/cclut_lut_writer.sv
// Write/readback/clear port for the CCLUT pattern tables; serialises
// config-register accesses onto the table port and keeps a write checksum.
module cclut_lut_writer
  import cclut_lut_writer_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [2:0]             cfg_pid,
  input  logic                   cfg_adr_ld,
  input  logic [MXADRB-1:0]      cfg_adr,
  input  logic                   cfg_autoinc,
  input  logic                   cfg_wr_stb,
  input  logic [MXDATB-1:0]      cfg_wr_data,
  input  logic                   cfg_rd_stb,
  output logic [MXDATB-1:0]      cfg_rd_data,
  output logic                   cfg_rd_valid,
  input  logic                   clear_req,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [MXADRB-1:0]      ptr,
  output logic                   wrap,
  output logic [15:0]            cksum,
  output logic [NTBL-1:0]        lut_we,
  output logic [MXADRB-1:0]      lut_adr,
  output logic [MXDATB-1:0]      lut_wdata,
  output logic                   lut_re,
  input  logic [NTBL*MXDATB-1:0] lut_rdata
);

  state_t              state, state_nx;
  logic [2:0]          pid_q;
  logic                pid_ok_q;
  logic                op_rd_q;
  logic                autoinc_q;
  logic [RDCNTB-1:0]   rd_cnt;
  logic [MXDATB-1:0]   rd_slice;

  logic                idle, any_stb, pid_ok;
  logic                start_clr, start_wr, start_rd, acc_adr;
  logic                clr_last, rd_cap, err_set, ptr_inc;
  logic [MXADRB-1:0]   acc_ptr;

  assign idle      = (state == ST_IDLE);
  assign any_stb   = cfg_wr_stb | cfg_rd_stb | clear_req | cfg_adr_ld;
  assign pid_ok    = pid_valid(cfg_pid);
  assign start_clr = idle & clear_req;
  assign start_wr  = idle & ~clear_req & cfg_wr_stb;
  assign start_rd  = idle & ~clear_req & ~cfg_wr_stb & cfg_rd_stb;
  assign acc_adr   = idle & ~clear_req & cfg_adr_ld;
  // A same-cycle pointer load redirects the access that starts with it.
  assign acc_ptr   = acc_adr ? cfg_adr : ptr;
  assign clr_last  = (lut_adr == '1);
  assign rd_cap    = (state == ST_RDWAIT) && (rd_cnt == RDCNTB'(RD_LAT));
  assign ptr_inc   = (state == ST_FIN) & autoinc_q;
  assign err_set   = (~idle & any_stb)
                   | ((start_wr | start_rd) & ~pid_ok)
                   | (start_wr & cfg_rd_stb);

  cclut_ptr_ctr u_ptr_ctr (
    .clock    (clock),
    .reset_n  (reset_n),
    .clr      (start_clr),
    .load     (acc_adr),
    .load_val (cfg_adr),
    .inc      (ptr_inc),
    .ptr      (ptr),
    .wrap     (wrap)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    busy         = ~idle;
    done         = 1'b0;
    cfg_rd_valid = 1'b0;
    lut_we       = '0;
    lut_re       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_clr)     state_nx = ST_CLEAR;
        else if (start_wr) state_nx = ST_WRITE;
        else if (start_rd) state_nx = ST_RDWAIT;
      end
      ST_WRITE: begin
        for (int unsigned k = 0; k < NTBL; k++)
          lut_we[k] = pid_ok_q && (pid_q == 3'(k));
        state_nx = ST_FIN;
      end
      ST_RDWAIT: begin
        lut_re = pid_ok_q && (rd_cnt == '0);
        if (rd_cap) state_nx = ST_FIN;
      end
      ST_CLEAR: begin
        lut_we = '1;
        if (clr_last) state_nx = ST_FIN;
      end
      ST_FIN: begin
        done         = 1'b1;
        cfg_rd_valid = op_rd_q & pid_ok_q;
        state_nx     = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_slice = '0;
    for (int unsigned k = 0; k < NTBL; k++)
      if (pid_q == 3'(k)) rd_slice = lut_rdata[k*MXDATB +: MXDATB];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pid_q       <= '0;
      pid_ok_q    <= 1'b0;
      op_rd_q     <= 1'b0;
      autoinc_q   <= 1'b0;
      rd_cnt      <= '0;
      cfg_rd_data <= '0;
      cksum       <= '0;
      lut_adr     <= '0;
      lut_wdata   <= '0;
      err         <= 1'b0;
    end else begin
      if (start_clr) begin
        lut_adr   <= '0;
        lut_wdata <= '0;
        cksum     <= '0;
        pid_ok_q  <= 1'b0;
        op_rd_q   <= 1'b0;
        autoinc_q <= 1'b0;
      end else if (start_wr | start_rd) begin
        pid_q     <= cfg_pid;
        pid_ok_q  <= pid_ok;
        op_rd_q   <= start_rd;
        autoinc_q <= cfg_autoinc;
        lut_adr   <= acc_ptr;
        rd_cnt    <= '0;
        if (start_wr) lut_wdata <= cfg_wr_data;
      end

      if (state == ST_CLEAR && !clr_last) lut_adr <= lut_adr + 1'b1;

      if (state == ST_RDWAIT) begin
        rd_cnt <= rd_cnt + 1'b1;
        if (rd_cap && pid_ok_q) cfg_rd_data <= rd_slice;
      end

      if (state == ST_WRITE && pid_ok_q) cksum <= cksum + 16'(lut_wdata);

      if (start_clr)    err <= 1'b0;
      else if (err_set) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cclut_lut_writer.sv
// Randomised self-checking bench for cclut_lut_writer with a table-level
// reference model and a behavioural RD_LAT=1 table memory on the LUT port.
module tb_cclut_lut_writer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [2:0]  cfg_pid;
  logic        cfg_adr_ld;
  logic [10:0] cfg_adr;
  logic        cfg_autoinc;
  logic        cfg_wr_stb;
  logic [8:0]  cfg_wr_data;
  logic        cfg_rd_stb;
  logic [8:0]  cfg_rd_data;
  logic        cfg_rd_valid;
  logic        clear_req;
  logic        busy, done, err, wrap;
  logic [10:0] ptr;
  logic [15:0] cksum;
  logic [4:0]  lut_we;
  logic [10:0] lut_adr;
  logic [8:0]  lut_wdata;
  logic        lut_re;
  logic [44:0] lut_rdata;

  cclut_lut_writer dut (
    .clock(clock), .reset_n(reset_n), .cfg_pid(cfg_pid), .cfg_adr_ld(cfg_adr_ld),
    .cfg_adr(cfg_adr), .cfg_autoinc(cfg_autoinc), .cfg_wr_stb(cfg_wr_stb),
    .cfg_wr_data(cfg_wr_data), .cfg_rd_stb(cfg_rd_stb), .cfg_rd_data(cfg_rd_data),
    .cfg_rd_valid(cfg_rd_valid), .clear_req(clear_req), .busy(busy), .done(done),
    .err(err), .ptr(ptr), .wrap(wrap), .cksum(cksum), .lut_we(lut_we),
    .lut_adr(lut_adr), .lut_wdata(lut_wdata), .lut_re(lut_re), .lut_rdata(lut_rdata)
  );

  always #5 clock = ~clock;

  // Table memory attached to the LUT port (one-clock registered read).
  logic [8:0]  mem [5][2048];
  logic [44:0] rd_q;
  assign lut_rdata = rd_q;
  always @(posedge clock) begin
    for (int k = 0; k < 5; k++)
      if (lut_we[k]) mem[k][lut_adr] <= lut_wdata;
    if (lut_re)
      for (int k = 0; k < 5; k++) rd_q[k*9 +: 9] <= mem[k][lut_adr];
  end

  // Reference model
  logic [8:0]  ref_tbl [5][2048];
  int          ref_ptr, ref_cksum;
  bit          ref_err, ref_wrap;
  int          n_checks = 0, n_errs = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic step_ptr(input bit ainc);
    if (ainc) begin
      ref_ptr = (ref_ptr + 1) % 2048;
      if (ref_ptr == 0) ref_wrap = 1'b1;
    end
  endtask

  task automatic post_check();
    check("post_busy",  busy,  0);
    check("post_ptr",   ptr,   ref_ptr);
    check("post_wrap",  wrap,  ref_wrap);
    check("post_err",   err,   ref_err);
    check("post_cksum", cksum, ref_cksum);
  endtask

  task automatic do_write(input int pid, input logic [8:0] data, input bit ld, input logic [10:0] adr);
    int a;
    bit ok;
    ok = (pid < 5);
    cfg_pid = 3'(pid); cfg_wr_data = data; cfg_adr_ld = ld; cfg_adr = adr; cfg_wr_stb = 1'b1;
    if (ld) ref_ptr = adr;
    a = ref_ptr;
    tick();
    cfg_wr_stb = 1'b0; cfg_adr_ld = 1'b0;
    check("wr_we", lut_we, ok ? (32'd1 << pid) : 32'd0);
    check("wr_done_early", done, 0);
    if (ok) begin
      check("wr_adr", lut_adr, a);
      check("wr_wdata", lut_wdata, data);
    end
    tick();
    check("wr_done", done, 1);
    check("wr_we_off", lut_we, 0);
    if (ok) ref_cksum = (ref_cksum + data) % 65536;
    else    ref_err = 1'b1;
    if (ok) ref_tbl[pid][a] = data;
    step_ptr(cfg_autoinc);
    tick();
    post_check();
    if (ok) check("wr_mem", mem[pid][a], ref_tbl[pid][a]);
  endtask

  task automatic do_read(input int pid, input bit ld, input logic [10:0] adr);
    int a;
    bit ok;
    ok = (pid < 5);
    cfg_pid = 3'(pid); cfg_adr_ld = ld; cfg_adr = adr; cfg_rd_stb = 1'b1;
    if (ld) ref_ptr = adr;
    a = ref_ptr;
    tick();
    cfg_rd_stb = 1'b0; cfg_adr_ld = 1'b0;
    check("rd_re", lut_re, ok);
    check("rd_we", lut_we, 0);
    if (ok) check("rd_adr", lut_adr, a);
    tick();
    check("rd_valid_early", cfg_rd_valid, 0);
    tick();
    check("rd_done", done, 1);
    if (ok) begin
      check("rd_valid", cfg_rd_valid, 1);
      check("rd_data", cfg_rd_data, ref_tbl[pid][a]);
    end else begin
      ref_err = 1'b1;
    end
    step_ptr(cfg_autoinc);
    tick();
    check("rd_valid_late", cfg_rd_valid, 0);
    post_check();
  endtask

  task automatic do_clear(input bit inject);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    ref_ptr = 0; ref_wrap = 1'b0; ref_err = 1'b0; ref_cksum = 0;
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < 2048; i++) ref_tbl[k][i] = '0;
    for (int i = 0; i < 2048; i++) begin
      check("clr_cycle", {busy, lut_we, lut_adr, lut_wdata}, {1'b1, 5'h1F, 11'(i), 9'h000});
      if (inject && i == 50) begin
        cfg_pid = 3'd0; cfg_wr_data = 9'h1FF; cfg_wr_stb = 1'b1;
      end
      if (inject && i == 51) cfg_wr_stb = 1'b0;
      tick();
    end
    if (inject) ref_err = 1'b1;
    check("clr_done", {busy, done, lut_we}, {1'b1, 1'b1, 5'h00});
    tick();
    check("clr_done_off", done, 0);
    post_check();
  endtask

  initial begin
    int r, pid;
    bit ld;
    logic [10:0] adr;
    logic [8:0] wd;

    reset_n = 1'b0; cfg_pid = '0; cfg_adr_ld = 1'b0; cfg_adr = '0; cfg_autoinc = 1'b0;
    cfg_wr_stb = 1'b0; cfg_wr_data = '0; cfg_rd_stb = 1'b0; clear_req = 1'b0;
    ref_ptr = 0; ref_cksum = 0; ref_err = 1'b0; ref_wrap = 1'b0;
    tick(); tick();
    check("rst_flags", {busy, done, err, wrap, lut_re, cfg_rd_valid, lut_we}, 0);
    check("rst_ptr", ptr, 0);
    check("rst_cksum", cksum, 0);
    check("rst_lut", {lut_adr, lut_wdata, cfg_rd_data}, 0);
    reset_n = 1'b1;
    tick();

    // Full clear also initialises the attached table memory.
    do_clear(1'b0);

    // Auto-increment burst across the top of the table.
    cfg_autoinc = 1'b1;
    do_write(2, 9'h1A5, 1'b1, 11'h7FE);
    do_write(2, 9'h0FF, 1'b0, 11'h000);
    do_write(2, 9'h003, 1'b0, 11'h000);
    check("burst_wrap", wrap, 1);
    check("burst_cksum", cksum, 16'h02A7);

    // Readback from table 4.
    cfg_autoinc = 1'b0;
    do_write(4, 9'h155, 1'b1, 11'h123);
    do_read(4, 1'b1, 11'h123);
    check("rb_data", cfg_rd_data, 9'h155);

    // Invalid table, then a write strobe while clearing.
    do_write(6, 9'h0AA, 1'b0, 11'h000);
    check("inv_err", err, 1);
    do_clear(1'b1);
    check("busy_stb_err", err, 1);
    check("busy_stb_cksum", cksum, 0);

    // Simultaneous write and read strobes.
    cfg_pid = 3'd0; cfg_wr_data = 9'h0C3; cfg_wr_stb = 1'b1; cfg_rd_stb = 1'b1;
    tick();
    cfg_wr_stb = 1'b0; cfg_rd_stb = 1'b0;
    check("dual_we", {lut_we, lut_re}, {5'b00001, 1'b0});
    tick();
    check("dual_done", {done, cfg_rd_valid}, {1'b1, 1'b0});
    ref_tbl[0][ref_ptr] = 9'h0C3;
    ref_cksum = (ref_cksum + 9'h0C3) % 65536;
    ref_err = 1'b1;
    tick();
    check("dual_rv", cfg_rd_valid, 0);
    post_check();

    // Randomised mix of writes and reads, valid and invalid tables.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 15);
      if (r == 15) cfg_autoinc = ~cfg_autoinc;
      ld  = ($urandom_range(0, 3) == 0);
      adr = ($urandom_range(0, 1) == 1) ? 11'($urandom_range(2040, 2047)) : 11'($urandom);
      pid = (r < 2) ? $urandom_range(5, 7) : $urandom_range(0, 4);
      wd  = 9'($urandom);
      if (r < 10) do_write(pid, wd, ld, adr);
      else        do_read(pid, ld, adr);
    end

    // Reset part-way through a clear.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    check("abort_adr", lut_adr, 100);
    reset_n = 1'b0;
    tick();
    check("abort_we", lut_we, 0);
    check("abort_busy", busy, 0);
    check("abort_ptr", ptr, 0);
    check("abort_cksum", cksum, 0);
    reset_n = 1'b1;
    tick(); tick();
    check("abort_idle", {busy, done, lut_we}, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
